// File: rtl/muldiv_pkg.sv
// Shared constants, RV32M funct3 encodings, FSM state type and operand-sign
// decode helpers for the multiply/divide execution unit.
package muldiv_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int TAG_W_DEF = 6;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  function automatic logic is_signed_a(input logic [2:0] f3);
    case (f3)
      F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

  function automatic logic is_signed_b(input logic [2:0] f3);
    case (f3)
      F3_MUL, F3_MULH, F3_DIV, F3_REM: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_divider_core.sv
// Iterative unsigned restoring divider: one quotient bit per cycle for XLEN cycles.
// done is high during the final step; quotient/remainder then show that step's result.
module muldiv_divider_core
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN + 1);

  logic [XLEN-1:0] quo_q, rem_q, dvs_q;
  logic [XLEN-1:0] quo_d, rem_d;
  logic [CW-1:0]   cnt_q;
  logic [XLEN:0]   trial, diff;
  logic            ge;

  // Partial remainder stays below the divisor, so the shifted trial fits in XLEN+1 bits
  assign trial = {rem_q, quo_q[XLEN-1]};
  assign diff  = trial - {1'b0, dvs_q};
  assign ge    = ~diff[XLEN];
  assign rem_d = ge ? diff[XLEN-1:0] : trial[XLEN-1:0];
  assign quo_d = {quo_q[XLEN-2:0], ge};

  assign done      = (cnt_q == CW'(1));
  assign quotient  = quo_d;
  assign remainder = rem_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
      cnt_q <= CW'(XLEN);
    end else if (cnt_q != '0) begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/mult_div_exec_unit.sv
// RV32M multiply/divide execution unit with issue handshake and CDB request/grant.
// Define MULDIV_GRANT_BYPASS_EN to accept a new op in the CDB grant cycle (no idle bubble).
module mult_div_exec_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN        = XLEN_DEF,
  parameter int TAG_W       = TAG_W_DEF,
  parameter int MUL_LATENCY = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  input  logic [2:0]       issue_funct3,
  input  logic [XLEN-1:0]  issue_rs1_data,
  input  logic [XLEN-1:0]  issue_rs2_data,
  input  logic [TAG_W-1:0] issue_rd_tag,
  output logic             issueblk_done,
  output logic             cdb_req,
  input  logic             cdb_grant,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [XLEN-1:0]  cdb_data
);

  localparam int PW = 2 * XLEN;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [2:0]       f3_q, f3_d;
  logic [XLEN-1:0]  a_q, a_d, b_q, b_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [XLEN-1:0]  data_q, data_d;

  logic             accept, div_start, div_zero_i, div_ovf_i, neg_a_i, neg_b_i;
  logic [XLEN-1:0]  a_mag_i, b_mag_i, special_res;
  logic             core_done;
  logic [XLEN-1:0]  core_quo, core_rem, div_res, mul_res;
  logic signed [XLEN:0] mul_a, mul_b;
  logic [PW-1:0]    prod;

`ifdef MULDIV_GRANT_BYPASS_EN
  assign issueblk_done = (state_q == IDLE) | ((state_q == DONE) & cdb_grant);
`else
  assign issueblk_done = (state_q == IDLE);
`endif

  assign accept   = issue_valid & issueblk_done;
  assign cdb_req  = (state_q == DONE);
  assign cdb_tag  = tag_q;
  assign cdb_data = data_q;

  // Issue-side decode: magnitudes and divide special cases resolved in the accept cycle
  assign neg_a_i    = is_signed_a(issue_funct3) & issue_rs1_data[XLEN-1];
  assign neg_b_i    = is_signed_b(issue_funct3) & issue_rs2_data[XLEN-1];
  assign a_mag_i    = neg_a_i ? -issue_rs1_data : issue_rs1_data;
  assign b_mag_i    = neg_b_i ? -issue_rs2_data : issue_rs2_data;
  assign div_zero_i = (issue_rs2_data == '0);
  assign div_ovf_i  = is_signed_a(issue_funct3)
                    & (issue_rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                    & (issue_rs2_data == '1);
  assign div_start  = accept & is_div(issue_funct3) & ~div_zero_i & ~div_ovf_i;

  always_comb begin
    special_res = '0;
    if (div_zero_i) special_res = issue_funct3[1] ? issue_rs1_data : '1;
    else            special_res = issue_funct3[1] ? '0 : issue_rs1_data;
  end

  muldiv_divider_core #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (a_mag_i),
    .divisor   (b_mag_i),
    .done      (core_done),
    .quotient  (core_quo),
    .remainder (core_rem)
  );

  // Sign-extended 33-bit operands; the low 2*XLEN bits of the product are exact
  assign mul_a   = {is_signed_a(f3_q) & a_q[XLEN-1], a_q};
  assign mul_b   = {is_signed_b(f3_q) & b_q[XLEN-1], b_q};
  assign prod    = PW'(mul_a) * PW'(mul_b);
  assign mul_res = (f3_q == F3_MUL) ? prod[XLEN-1:0] : prod[PW-1:XLEN];

  always_comb begin
    div_res = '0;
    if (f3_q[1]) div_res = (is_signed_a(f3_q) & a_q[XLEN-1]) ? -core_rem : core_rem;
    else         div_res = (is_signed_a(f3_q) & (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -core_quo : core_quo;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    a_d     = a_q;
    b_d     = b_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (accept) begin
      f3_d  = issue_funct3;
      a_d   = issue_rs1_data;
      b_d   = issue_rs2_data;
      tag_d = issue_rd_tag;
      if (!is_div(issue_funct3)) begin
        state_d = MUL;
        cnt_d   = 4'(MUL_LATENCY - 1);
      end else if (div_zero_i || div_ovf_i) begin
        state_d = DONE;
        data_d  = special_res;
      end else begin
        state_d = DIV;
      end
    end else begin
      case (state_q)
        MUL: begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = DONE;
            data_d  = mul_res;
          end
        end
        DIV: begin
          if (core_done) begin
            state_d = DONE;
            data_d  = div_res;
          end
        end
        DONE:    if (cdb_grant) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      f3_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_mult_div_exec_unit.sv
// Directed testbench for mult_div_exec_unit with hand-computed expected results.
// The grant-cycle bypass section is built only when MULDIV_GRANT_BYPASS_EN is defined.
module tb_mult_div_exec_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        issue_valid = 1'b0;
  logic [2:0]  issue_funct3 = '0;
  logic [31:0] issue_rs1_data = '0;
  logic [31:0] issue_rs2_data = '0;
  logic [5:0]  issue_rd_tag = '0;
  logic        issueblk_done;
  logic        cdb_req;
  logic        cdb_grant = 1'b0;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;

  int n_checks = 0;
  int n_errors = 0;

  mult_div_exec_unit #(.XLEN(32), .TAG_W(6), .MUL_LATENCY(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .issue_valid    (issue_valid),
    .issue_funct3   (issue_funct3),
    .issue_rs1_data (issue_rs1_data),
    .issue_rs2_data (issue_rs2_data),
    .issue_rd_tag   (issue_rd_tag),
    .issueblk_done  (issueblk_done),
    .cdb_req        (cdb_req),
    .cdb_grant      (cdb_grant),
    .cdb_tag        (cdb_tag),
    .cdb_data       (cdb_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Presents one op for a single cycle; returns just after the accept edge (cycle 1)
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] tag);
    @(negedge clk);
    issue_funct3   = f3;
    issue_rs1_data = a;
    issue_rs2_data = b;
    issue_rd_tag   = tag;
    issue_valid    = 1'b1;
    @(posedge clk);
    #1 issue_valid = 1'b0;
  endtask

  task automatic wait_req(output int lat);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (cdb_req) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic grant_and_release(input string name);
    cdb_grant = 1'b1;
    @(posedge clk);
    #1 cdb_grant = 1'b0;
    @(negedge clk);
    check({name, "_req_low"}, 32'(cdb_req), 32'd0);
    @(negedge clk);
    check({name, "_idle"}, 32'(issueblk_done), 32'd1);
  endtask

  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [5:0] tag,
                        input logic [31:0] exp, input int exp_lat);
    int lat;
    issue(f3, a, b, tag);
    check({name, "_busy"}, 32'(issueblk_done), 32'd0);
    wait_req(lat);
    check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    check({name, "_data"}, cdb_data, exp);
    check({name, "_tag"}, 32'(cdb_tag), 32'(tag));
    grant_and_release(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int reqs;

    #2 rst_n = 1'b0;
    #1;
    check("rst_idle", 32'(issueblk_done), 32'd1);
    check("rst_req", 32'(cdb_req), 32'd0);
    check("rst_tag", 32'(cdb_tag), 32'd0);
    check("rst_data", cdb_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("mul",     F3_MUL,    32'd7,        32'hFFFFFFFD, 6'd1,  32'hFFFFFFEB, 4);
    run_op("mulhu",   F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 6'd2,  32'hFFFFFFFE, 4);
    run_op("mulhsu",  F3_MULHSU, 32'hFFFFFFFF, 32'd2,        6'd3,  32'hFFFFFFFF, 4);
    run_op("mulh",    F3_MULH,   32'hFFFFFFFF, 32'd2,        6'd4,  32'hFFFFFFFF, 4);
    run_op("mulh_pp", F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 6'd5,  32'h00000000, 4);
    run_op("div",     F3_DIV,    32'hFFFFFFEC, 32'd3,        6'd6,  32'hFFFFFFFA, 33);
    run_op("rem",     F3_REM,    32'hFFFFFFEC, 32'd3,        6'd7,  32'hFFFFFFFE, 33);
    run_op("divu",    F3_DIVU,   32'd100,      32'd7,        6'd8,  32'd14,       33);
    run_op("remu",    F3_REMU,   32'd100,      32'd7,        6'd9,  32'd2,        33);
    run_op("divu_big",F3_DIVU,   32'hFFFFFFFF, 32'd1,        6'd10, 32'hFFFFFFFF, 33);
    run_op("div_z",   F3_DIV,    32'h00001234, 32'd0,        6'd11, 32'hFFFFFFFF, 1);
    run_op("remu_z",  F3_REMU,   32'd5,        32'd0,        6'd12, 32'd5,        1);
    run_op("div_ovf", F3_DIV,    32'h80000000, 32'hFFFFFFFF, 6'd13, 32'h80000000, 1);
    run_op("rem_ovf", F3_REM,    32'h80000000, 32'hFFFFFFFF, 6'd14, 32'd0,        1);

    // Grant withheld: result must hold while new issue attempts are refused
    issue(F3_MUL, 32'd3, 32'd5, 6'h2A);
    wait_req(lat);
    check("hold_lat", 32'(lat), 32'd4);
    for (int i = 0; i < 5; i++) begin
      check("hold_req", 32'(cdb_req), 32'd1);
      check("hold_tag", 32'(cdb_tag), 32'h2A);
      check("hold_data", cdb_data, 32'd15);
      check("hold_busy", 32'(issueblk_done), 32'd0);
      issue_funct3   = F3_DIV;
      issue_rs1_data = 32'd77;
      issue_rs2_data = 32'd0;
      issue_rd_tag   = 6'd1;
      issue_valid    = 1'b1;
      @(negedge clk);
    end
    issue_valid = 1'b0;
    check("hold_data_end", cdb_data, 32'd15);
    check("hold_tag_end", 32'(cdb_tag), 32'h2A);
    grant_and_release("hold");
    reqs = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cdb_req) reqs++;
    end
    check("hold_no_stray_op", 32'(reqs), 32'd0);

    // Reset in the middle of a divide discards it
    issue(F3_DIV, 32'd1000, 32'd3, 6'd5);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_idle", 32'(issueblk_done), 32'd1);
    check("midrst_req", 32'(cdb_req), 32'd0);
    check("midrst_data", cdb_data, 32'd0);
    check("midrst_tag", 32'(cdb_tag), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    reqs = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cdb_req) reqs++;
    end
    check("midrst_no_req", 32'(reqs), 32'd0);
    run_op("divu_after_rst", F3_DIVU, 32'd9, 32'd2, 6'd7, 32'd4, 33);

`ifdef MULDIV_GRANT_BYPASS_EN
    issue(F3_MUL, 32'd2, 32'd3, 6'd1);
    wait_req(lat);
    check("byp_first_data", cdb_data, 32'd6);
    cdb_grant      = 1'b1;
    issue_funct3   = F3_DIV;
    issue_rs1_data = 32'd7;
    issue_rs2_data = 32'd0;
    issue_rd_tag   = 6'd3;
    issue_valid    = 1'b1;
    #1;
    check("byp_done_in_grant", 32'(issueblk_done), 32'd1);
    check("byp_data_held", cdb_data, 32'd6);
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    cdb_grant   = 1'b0;
    check("byp_req_b2b", 32'(cdb_req), 32'd1);
    check("byp_data2", cdb_data, 32'hFFFFFFFF);
    check("byp_tag2", 32'(cdb_tag), 32'd3);
    @(negedge clk);
    grant_and_release("byp");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
